// File: rtl/issue_ctrl_if.sv
// issue_ctrl_if
//   Bundles the fetch-side and back-end-side signals of the in-order issue
//   controller so one handle connects the controller to its environment.
//   Clock and reset are not part of the bundle.
//
//   Signal summary (direction as seen by the controller, modport slave):
//     rdy_in         in   global ready; low freezes the controller
//     if_valid_in    in   fetch presents an instruction
//     if_inst_in     in   fetched instruction word [31:0]
//     if_pc_in       in   PC of the fetched instruction [31:0]
//     if_full_out    out  queue full, fetch must hold
//     dec_inst_out   out  queue head instruction to the decoder [31:0]
//     dec_issue_out  out  queue non-empty
//     rob_full_in    in   ROB has no free entry
//     rs_full_in     in   reservation station full
//     lsb_full_in    in   load/store buffer full
//     rob_tag_in     in   tag of next free ROB entry [ROB_TAG_W-1:0]
//     flush_in       in   mispredict, discard queue contents
//     issue_rob_out  out  allocate ROB entry this cycle
//     issue_rs_out   out  write head into RS this cycle
//     issue_lsb_out  out  write head into LSB this cycle
//     issue_pc_out   out  PC of the issued instruction [31:0]
//     issue_tag_out  out  ROB tag assigned to the issued instruction
//
//   modport slave  : used by issue_ctrl
//   modport master : used by whatever drives fetch/back-end side (e.g. a bench)
interface issue_ctrl_if #(
  parameter int ROB_TAG_W = 4
);
  logic                 rdy_in;
  logic                 if_valid_in;
  logic [31:0]          if_inst_in;
  logic [31:0]          if_pc_in;
  logic                 if_full_out;
  logic [31:0]          dec_inst_out;
  logic                 dec_issue_out;
  logic                 rob_full_in;
  logic                 rs_full_in;
  logic                 lsb_full_in;
  logic [ROB_TAG_W-1:0] rob_tag_in;
  logic                 flush_in;
  logic                 issue_rob_out;
  logic                 issue_rs_out;
  logic                 issue_lsb_out;
  logic [31:0]          issue_pc_out;
  logic [ROB_TAG_W-1:0] issue_tag_out;

  modport slave (
    input  rdy_in, if_valid_in, if_inst_in, if_pc_in,
    input  rob_full_in, rs_full_in, lsb_full_in, rob_tag_in, flush_in,
    output if_full_out, dec_inst_out, dec_issue_out,
    output issue_rob_out, issue_rs_out, issue_lsb_out, issue_pc_out, issue_tag_out
  );

  modport master (
    output rdy_in, if_valid_in, if_inst_in, if_pc_in,
    output rob_full_in, rs_full_in, lsb_full_in, rob_tag_in, flush_in,
    input  if_full_out, dec_inst_out, dec_issue_out,
    input  issue_rob_out, issue_rs_out, issue_lsb_out, issue_pc_out, issue_tag_out
  );
endinterface

// File: rtl/issue_ctrl.sv
// issue_ctrl
//   In-order issue controller between instruction fetch and the out-of-order
//   back end. Fetched instructions are buffered in a circular instruction
//   queue; the head is shown to the decoder and dispatched to the ROB plus
//   either the RS or the LSB once every structure it needs has room.
//   A mispredict flush empties the queue.
//
//   Ports:
//     clk_in         in   clock, rising edge
//     rst_in         in   asynchronous active-high reset
//     bus            issue_ctrl_if.slave, fetch/decoder/back-end handshake
//     stall_cnt_out  out  [31:0] saturating count of cycles the head was
//                         present but blocked (only with ISSUE_STALL_CNT_EN)
//
//   Optional feature macro: ISSUE_STALL_CNT_EN
module issue_ctrl #(
  parameter int IQ_DEPTH_LOG = 3,
  parameter int ROB_TAG_W    = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
`ifdef ISSUE_STALL_CNT_EN
  output logic [31:0] stall_cnt_out,
`endif
  issue_ctrl_if.slave bus
);

  localparam int DEPTH = 2 ** IQ_DEPTH_LOG;
  localparam logic [IQ_DEPTH_LOG:0] DEPTH_CNT = (IQ_DEPTH_LOG + 1)'(DEPTH);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic [31:0]             inst_q [DEPTH];
  logic [31:0]             pc_q   [DEPTH];
  logic [IQ_DEPTH_LOG-1:0] head_q, head_d;
  logic [IQ_DEPTH_LOG-1:0] tail_q, tail_d;
  logic [IQ_DEPTH_LOG:0]   count_q, count_d;

  logic        full;
  logic        not_empty;
  logic        push;
  logic        go;
  logic        is_mem;
  logic [31:0] head_inst;

  // Queue status and issue decision, all from registered state plus this
  // cycle's back-end inputs. Full only looks at the registered count, so a
  // pop in the same cycle never makes room for a push.
  always_comb begin
    head_inst = inst_q[head_q];
    full      = (count_q == DEPTH_CNT);
    not_empty = (count_q != '0);
    is_mem    = (head_inst[6:0] == OP_LOAD) || (head_inst[6:0] == OP_STORE);
    push      = bus.rdy_in & bus.if_valid_in & ~full & ~bus.flush_in;
    go        = bus.rdy_in & not_empty & ~bus.flush_in & ~bus.rob_full_in &
                (is_mem ? ~bus.lsb_full_in : ~bus.rs_full_in);
  end

  // Outputs toward fetch, decoder and back end.
  always_comb begin
    bus.if_full_out   = full;
    bus.dec_inst_out  = head_inst;
    bus.dec_issue_out = not_empty;
    bus.issue_rob_out = go;
    bus.issue_lsb_out = go & is_mem;
    bus.issue_rs_out  = go & ~is_mem;
    bus.issue_pc_out  = pc_q[head_q];
    bus.issue_tag_out = bus.rob_tag_in;
  end

  // Pointer and occupancy update. Flush wins over push and pop; a frozen
  // cycle (rdy low) leaves everything as is because push and go are both 0.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.rdy_in && bus.flush_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (go)   head_d = head_q + 1'b1;
      case ({push, go})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is cleared on reset so the decoder and PC outputs read zero
  // while the queue is empty after reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (push) begin
      inst_q[tail_q] <= bus.if_inst_in;
      pc_q[tail_q]   <= bus.if_pc_in;
    end
  end

`ifdef ISSUE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Counts cycles where a head exists but cannot leave; flush does not clear
  // it so the figure survives mispredicts.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stall_cnt_q <= '0;
    end else if (bus.rdy_in && not_empty && !bus.flush_in && !go &&
                 stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_out = stall_cnt_q;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl
//   Directed bench for issue_ctrl. Inputs change 1 time unit after each rising
//   edge; combinational outputs are checked one more unit later, well away
//   from the next edge. Build with +define+ISSUE_STALL_CNT_EN to include the
//   stall counter steps.
module tb_issue_ctrl;

  localparam logic [31:0] ADDI = 32'h0000_0013;
  localparam logic [31:0] LW   = 32'h0000_2003;
  localparam logic [31:0] SW   = 32'h0000_2023;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   errors = 0;
  int   checks = 0;

`ifdef ISSUE_STALL_CNT_EN
  logic [31:0] stall_cnt_out;
`endif

  issue_ctrl_if #(.ROB_TAG_W(4)) bus ();

  issue_ctrl #(.IQ_DEPTH_LOG(3), .ROB_TAG_W(4)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
`ifdef ISSUE_STALL_CNT_EN
    .stall_cnt_out (stall_cnt_out),
`endif
    .bus           (bus)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] inst,
                               input logic [31:0] pc);
    bus.if_valid_in = valid;
    bus.if_inst_in  = inst;
    bus.if_pc_in    = pc;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkIssue(input string tag, input logic rob, input logic rs,
                            input logic lsb, input logic [31:0] pc);
    checkOutput({tag, ".strobes"},
                {29'd0, bus.issue_rob_out, bus.issue_rs_out, bus.issue_lsb_out},
                {29'd0, rob, rs, lsb});
    if (rob) checkOutput({tag, ".pc"}, bus.issue_pc_out, pc);
  endtask

  initial begin
    bus.rdy_in      = 1'b1;
    bus.if_valid_in = 1'b0;
    bus.if_inst_in  = '0;
    bus.if_pc_in    = '0;
    bus.rob_full_in = 1'b0;
    bus.rs_full_in  = 1'b0;
    bus.lsb_full_in = 1'b0;
    bus.rob_tag_in  = 4'hA;
    bus.flush_in    = 1'b0;

    // Reset state
    #12;
    checkOutput("reset.full",  {31'd0, bus.if_full_out},   32'd0);
    checkOutput("reset.dec",   {31'd0, bus.dec_issue_out}, 32'd0);
    checkOutput("reset.inst",  bus.dec_inst_out,           32'd0);
    checkIssue("reset", 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("reset.pc",    bus.issue_pc_out,           32'd0);
    rst_in = 1'b0;
    tick();

    // Test 1: three ADDI back to back, each issues the cycle after its push
    applyStimulus(1'b1, ADDI, 32'd0);
    checkIssue("t1.c0", 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b1, ADDI | 32'h0010_0000, 32'd4);
    checkIssue("t1.c1", 1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("t1.tag", {28'd0, bus.issue_tag_out}, 32'hA);
    tick();
    applyStimulus(1'b1, ADDI | 32'h0020_0000, 32'd8);
    checkIssue("t1.c2", 1'b1, 1'b1, 1'b0, 32'd4);
    checkOutput("t1.inst", bus.dec_inst_out, ADDI | 32'h0010_0000);
    tick();
    applyStimulus(1'b0, '0, '0);
    checkIssue("t1.c3", 1'b1, 1'b1, 1'b0, 32'd8);
    tick();
    checkOutput("t1.empty", {31'd0, bus.dec_issue_out}, 32'd0);

    // Test 2: LW blocked by LSB full for 4 cycles, then one LSB pulse
    bus.lsb_full_in = 1'b1;
    applyStimulus(1'b1, LW, 32'h100);
    tick();
    applyStimulus(1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      checkIssue("t2.stall", 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("t2.head", bus.issue_pc_out, 32'h100);
      tick();
    end
    bus.lsb_full_in = 1'b0;
    #1;
    checkIssue("t2.go", 1'b1, 1'b0, 1'b1, 32'h100);
    tick();
    checkIssue("t2.after", 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("t2.empty", {31'd0, bus.dec_issue_out}, 32'd0);

    // Test 3: ROB full, fill the queue; pushes into a full queue are dropped,
    // including one that coincides with the first pop
    bus.rob_full_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, ADDI | (32'(i) << 20), 32'h200 + 32'(4 * i));
      checkOutput("t3.notfull", {31'd0, bus.if_full_out}, 32'd0);
      tick();
    end
    applyStimulus(1'b1, ADDI | 32'h0FF0_0000, 32'h300);
    checkOutput("t3.full", {31'd0, bus.if_full_out}, 32'd1);
    checkIssue("t3.blocked", 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    bus.rob_full_in = 1'b0;
    applyStimulus(1'b1, ADDI | 32'h0FE0_0000, 32'h304);
    checkOutput("t3.fullpop", {31'd0, bus.if_full_out}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      checkIssue("t3.drain", 1'b1, 1'b1, 1'b0, 32'h200 + 32'(4 * i));
      checkOutput("t3.inst", bus.dec_inst_out, ADDI | (32'(i) << 20));
      tick();
      applyStimulus(1'b0, '0, '0);
    end
    checkOutput("t3.empty", {31'd0, bus.dec_issue_out}, 32'd0);

    // Test 4: five queued, flush with a concurrent fetch
    bus.rob_full_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, ADDI, 32'h400 + 32'(4 * i));
      tick();
    end
    bus.rob_full_in = 1'b0;
    bus.flush_in    = 1'b1;
    applyStimulus(1'b1, ADDI, 32'h500);
    checkIssue("t4.flush", 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    bus.flush_in = 1'b0;
    applyStimulus(1'b0, '0, '0);
    checkOutput("t4.empty", {31'd0, bus.dec_issue_out}, 32'd0);
    checkIssue("t4.after", 1'b0, 1'b0, 1'b0, 32'd0);

    // Test 5: 20 instructions streamed, pointers wrap twice
    for (int k = 0; k <= 20; k++) begin
      if (k < 20) applyStimulus(1'b1, ADDI | (32'(k) << 20), 32'h1000 + 32'(4 * k));
      else        applyStimulus(1'b0, '0, '0);
      if (k == 0) begin
        checkOutput("t5.start", {31'd0, bus.dec_issue_out}, 32'd0);
      end else begin
        checkIssue("t5.issue", 1'b1, 1'b1, 1'b0, 32'h1000 + 32'(4 * (k - 1)));
        checkOutput("t5.inst", bus.dec_inst_out, ADDI | (32'(k - 1) << 20));
        checkOutput("t5.full", {31'd0, bus.if_full_out}, 32'd0);
      end
      tick();
    end
    checkOutput("t5.empty", {31'd0, bus.dec_issue_out}, 32'd0);

    // rdy low freezes: no issue, no push
    applyStimulus(1'b1, ADDI, 32'h2000);
    tick();
    bus.rdy_in = 1'b0;
    applyStimulus(1'b1, ADDI, 32'h2004);
    checkIssue("rdy.low", 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    bus.rdy_in = 1'b1;
    applyStimulus(1'b0, '0, '0);
    checkIssue("rdy.high", 1'b1, 1'b1, 1'b0, 32'h2000);
    tick();
    checkOutput("rdy.empty", {31'd0, bus.dec_issue_out}, 32'd0);

    // Async reset between edges empties the queue at once
    bus.rob_full_in = 1'b1;
    applyStimulus(1'b1, ADDI, 32'h3000);
    tick();
    applyStimulus(1'b0, '0, '0);
    checkOutput("arst.before", {31'd0, bus.dec_issue_out}, 32'd1);
    rst_in = 1'b1;
    #1;
    checkOutput("arst.dec",  {31'd0, bus.dec_issue_out}, 32'd0);
    checkOutput("arst.inst", bus.dec_inst_out,           32'd0);
    #1;
    rst_in = 1'b0;
    bus.rob_full_in = 1'b0;
    tick();

`ifdef ISSUE_STALL_CNT_EN
    // Test 6: SW blocked 7 cycles gives a stall count of 7
    checkOutput("t6.zero", stall_cnt_out, 32'd0);
    bus.lsb_full_in = 1'b1;
    applyStimulus(1'b1, SW, 32'h4000);
    tick();
    applyStimulus(1'b0, '0, '0);
    for (int i = 0; i < 7; i++) tick();
    bus.lsb_full_in = 1'b0;
    #1;
    checkOutput("t6.count", stall_cnt_out, 32'd7);
    checkIssue("t6.go", 1'b1, 1'b0, 1'b1, 32'h4000);
    tick();
    checkOutput("t6.hold", stall_cnt_out, 32'd7);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
